alu2_shift_dispatch: RTL and testbench

Issue-side front end for the ALU2 iterative shifter. It accepts decoded SLL/SRL/SRA operations over a valid/ready handshake and launches them on the `shift` unit with a one-cycle start pulse. It then waits for `done` and presents the tagged result to writeback over a second valid/ready handshake. A pipeline flush is supported: an in-flight shift is drained and its result discarded.

---
 rtl/alu2_shift_dispatch.sv | 113 +++++++++++
 tb/tb_alu2_shift_dispatch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu2_shift_dispatch.sv
// Issue-side front end for the ALU2 iterative shifter: accept, launch, wait, return tagged result.
// Optional ALU2_SHIFT_ZERO_BYPASS_EN: zero-amount legal ops bypass the shifter entirely.

package core_config_pkg;
  parameter int XLEN = 32;
endpackage

module alu2_shift_dispatch #(
  parameter int XLEN  = core_config_pkg::XLEN,
  parameter int TAG_W = 5,
  parameter int SHW   = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             sh_start,
  output logic [XLEN-1:0]  sh_data,
  output logic [SHW-1:0]   sh_amount,
  output logic             sh_left,
  output logic             sh_arith,
  input  logic [XLEN-1:0]  sh_data_out,
  input  logic             sh_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0] state;
  logic       accept;
  logic       legal;
  logic       unused_rs2;

  // Upper amount bits are architecturally ignored: the amount wraps to SHW bits.
  assign unused_rs2 = ^in_rs2[XLEN-1:SHW];

  assign in_ready  = (state == S_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign legal     = (in_op != 2'b10);
  assign sh_start  = (state == S_ISSUE);
  assign out_valid = (state == S_RESULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sh_data   <= '0;
      sh_amount <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sh_data   <= in_rs1;
            sh_amount <= in_rs2[SHW-1:0];
            sh_left   <= (in_op == 2'b00);
            sh_arith  <= (in_op == 2'b11);
            out_tag   <= in_tag;
            out_err   <= !legal;
            if (!legal) begin
              out_data <= '0;
              state    <= S_RESULT;
            end
`ifdef ALU2_SHIFT_ZERO_BYPASS_EN
            else if (in_rs2[SHW-1:0] == '0) begin
              out_data <= in_rs1;
              state    <= S_RESULT;
            end
`endif
            else begin
              state <= S_ISSUE;
            end
          end
        end
        // sh_done may still be high from the previous op here; it is ignored.
        S_ISSUE: state <= flush ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (sh_done) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              out_data <= sh_data_out;
              state    <= S_RESULT;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        // Flush beats a same-cycle writeback handshake.
        S_RESULT: if (flush || out_ready) state <= S_IDLE;
        S_DRAIN:  if (sh_done) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu2_shift_dispatch.sv
// Directed bench for alu2_shift_dispatch with a behavioural iterative shifter and a result scoreboard.
module tb_alu2_shift_dispatch;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0]  in_op = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, sh_start, sh_left, sh_arith, out_valid, out_err;
  logic [31:0] sh_data, out_data;
  logic [4:0]  sh_amount, out_tag;

  logic [31:0] sm_res;
  logic [4:0]  sm_cnt;
  logic        sm_busy, sm_done;

  exp_t q[$];
  int tests = 0, fails = 0, starts = 0;

  alu2_shift_dispatch #(.XLEN(32), .TAG_W(5), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .sh_start(sh_start), .sh_data(sh_data), .sh_amount(sh_amount),
    .sh_left(sh_left), .sh_arith(sh_arith),
    .sh_data_out(sm_res), .sh_done(sm_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Iterative shifter model: done rises amount+1 edges after the start edge, held until next start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_res <= '0; sm_cnt <= '0; sm_busy <= 1'b0; sm_done <= 1'b0;
    end else if (sh_start) begin
      sm_busy <= 1'b1;
      sm_done <= 1'b0;
      sm_cnt  <= sh_amount;
      sm_res  <= sh_left ? (sh_data << sh_amount) :
                 sh_arith ? 32'($signed(sh_data) >>> sh_amount) : (sh_data >> sh_amount);
    end else if (sm_busy) begin
      if (sm_cnt == 0) begin
        sm_done <= 1'b1;
        sm_busy <= 1'b0;
      end else begin
        sm_cnt <= sm_cnt - 5'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    exp_t r;
    r.t = t;
    r.e = (op == 2'b10);
    case (op)
      2'b00:   r.d = a << b[4:0];
      2'b01:   r.d = a >> b[4:0];
      2'b11:   r.d = 32'($signed(a) >>> b[4:0]);
      default: r.d = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: every completed writeback handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sh_start) starts++;
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_tag", 32'(out_tag), 32'(e.t));
          chk("out_err", 32'(out_err), 32'(e.e));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input bit push);
    @(posedge clk); #1;
    in_op = op; in_rs1 = a; in_rs2 = b; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_accept", 32'(in_ready), 32'd1);
    if (push) q.push_back(model(op, a, b, t));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the accept edge) where out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
      if (cyc > 60) begin
        chk("wait_valid_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_ready(input int start, output int cyc, output bit saw_valid);
    cyc = start;
    saw_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (out_valid) saw_valid = 1'b1;
      if (in_ready) break;
      if (cyc > start + 80) begin
        chk("wait_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    int cyc, s0;
    bit saw;
    exp_t e0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sh_start", 32'(sh_start), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset while waiting on the shifter
    send(2'b01, 32'h0000_F0F0, 32'd20, 5'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sh_data", sh_data, 32'd0);
    chk("mid_rst_sh_amount", 32'(sh_amount), 32'd0);
    chk("mid_rst_sh_flags", {30'd0, sh_left, sh_arith}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("post_rst_no_stale_valid", 32'(saw), 32'd0);

    // SRA with writeback backpressure
    out_ready = 1'b0;
    s0 = starts;
    send(2'b11, 32'h8000_00F0, 32'd4, 5'd7, 1'b1);
    @(negedge clk);
    chk("sra_sh_start", 32'(sh_start), 32'd1);
    chk("sra_sh_amount", 32'(sh_amount), 32'd4);
    chk("sra_sh_arith", 32'(sh_arith), 32'd1);
    chk("sra_sh_left", 32'(sh_left), 32'd0);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      chk("sra_hold_valid", 32'(out_valid), 32'd1);
      chk("sra_hold_data", out_data, 32'hF800_000F);
      chk("sra_hold_tag", 32'(out_tag), 32'd7);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("sra_valid_dropped", 32'(out_valid), 32'd0);
    chk("sra_in_ready_back", 32'(in_ready), 32'd1);
    chk("sra_single_start", 32'(starts - s0), 32'd1);

    // SLL with wrapped amount, SRL by 31
    e0 = model(2'b00, 32'd1, 32'h25, 5'd3);
    chk("sll_model_const", e0.d, 32'h20);
    send(2'b00, 32'd1, 32'h25, 5'd3, 1'b1);
    @(negedge clk);
    chk("sll_sh_amount_wrap", 32'(sh_amount), 32'd5);
    chk("sll_sh_left", 32'(sh_left), 32'd1);
    wait_valid(cyc);
    send(2'b01, 32'hFFFF_FFFF, 32'd31, 5'd4, 1'b1);
    wait_valid(cyc);
    chk("srl31_data", out_data, 32'h1);

    // Illegal op: immediate error result, no launch
    s0 = starts;
    send(2'b10, 32'hDEAD_BEEF, 32'd3, 5'd9, 1'b1);
    wait_valid(cyc);
    chk("illegal_latency", 32'(cyc), 32'd1);
    chk("illegal_err", 32'(out_err), 32'd1);
    chk("illegal_data", out_data, 32'd0);
    chk("illegal_no_start", 32'(starts - s0), 32'd0);

    // Flush in WAIT: drained, ready only after done
    send(2'b01, 32'hAAAA_5555, 32'd20, 5'd5, 1'b0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_ready(2, cyc, saw);
    chk("flush_wait_no_valid", 32'(saw), 32'd0);
    chk("flush_wait_ready_cycle", 32'(cyc), 32'd24);
    send(2'b00, 32'd3, 32'd2, 5'd6, 1'b1);
    wait_valid(cyc);
    chk("after_flush_data", out_data, 32'd12);

    // Flush in ISSUE: pulse still issued, result dropped
    send(2'b00, 32'd7, 32'd3, 5'd1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_issue_start", 32'(sh_start), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    wait_ready(2, cyc, saw);
    chk("flush_issue_no_valid", 32'(saw), 32'd0);

    // Flush in RESULT beats a same-cycle out_ready
    send(2'b10, 32'd5, 32'd0, 5'd3, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_result_valid_before", 32'(out_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_result_valid_after", 32'(out_valid), 32'd0);
    chk("flush_result_in_ready", 32'(in_ready), 32'd1);

    // Amount zero
    s0 = starts;
    send(2'b00, 32'h1234, 32'd0, 5'd8, 1'b1);
    wait_valid(cyc);
    chk("zero_data", out_data, 32'h1234);
`ifdef ALU2_SHIFT_ZERO_BYPASS_EN
    chk("zero_latency", 32'(cyc), 32'd1);
    chk("zero_starts", 32'(starts - s0), 32'd0);
`else
    chk("zero_latency", 32'(cyc), 32'd4);
    chk("zero_starts", 32'(starts - s0), 32'd1);
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
